// File: rtl/tx_intr_moderator.sv
// Transmit interrupt moderation: ICR/IMS/ICS/IMC cause registers plus TIDV/TADV
// delay timers driven by a 1.024 us prescaler tick, producing a registered intr level.
module tx_intr_moderator #(
    parameter int TICK_DIV = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        soft_rst,
    input  logic        wb_valid,
    input  logic        wb_ide,
    input  logic        txqe_evt,
    input  logic        txdlow_evt,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [15:0] reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_rvalid,
    output logic        intr
);

    localparam logic [15:0] ADDR_ICR  = 16'h00C0;
    localparam logic [15:0] ADDR_ICS  = 16'h00C8;
    localparam logic [15:0] ADDR_IMS  = 16'h00D0;
    localparam logic [15:0] ADDR_IMC  = 16'h00D8;
    localparam logic [15:0] ADDR_TIDV = 16'h3820;
    localparam logic [15:0] ADDR_TADV = 16'h382C;
    localparam int          PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Cause bits are kept packed as {TXD_LOW, TXQE, TXDW} and spread to 15/1/0 on read.
    logic [2:0]    r_icr;
    logic [2:0]    r_ims;
    logic [15:0]   r_tidv;
    logic [15:0]   r_tadv;
    logic [15:0]   r_dly;
    logic [15:0]   r_abs;
    logic          r_dly_run;
    logic          r_abs_run;
    logic [PW-1:0] r_presc;

    logic          w_any_rst;
    logic          w_tick;
    logic          w_reload;
    logic          w_immediate;
    logic          w_dly_exp;
    logic          w_abs_exp;
    logic          w_txdw_set;
    logic          w_icr_rd;
    logic          w_icr_wr;
    logic          w_ics_wr;
    logic          w_ims_wr;
    logic          w_imc_wr;
    logic [2:0]    w_wbits;
    logic [2:0]    w_icr_set;
    logic [2:0]    w_icr_clr;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_any_rst   = rst | soft_rst;
    assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
    assign w_reload    = wb_valid & wb_ide & (r_tidv != 16'd0);
    assign w_immediate = wb_valid & (~wb_ide | (r_tidv == 16'd0));
    // A delay reload in the same cycle masks the DLY expiry; ABS expiry is unaffected.
    assign w_dly_exp   = r_dly_run & w_tick & (r_dly == 16'd1) & ~w_reload;
    assign w_abs_exp   = r_abs_run & w_tick & (r_abs == 16'd1);
    assign w_txdw_set  = w_immediate | w_dly_exp | w_abs_exp;

    assign w_icr_rd  = reg_rd & (reg_addr == ADDR_ICR);
    assign w_icr_wr  = reg_wr & (reg_addr == ADDR_ICR);
    assign w_ics_wr  = reg_wr & (reg_addr == ADDR_ICS);
    assign w_ims_wr  = reg_wr & (reg_addr == ADDR_IMS);
    assign w_imc_wr  = reg_wr & (reg_addr == ADDR_IMC);
    assign w_wbits   = {reg_wdata[15], reg_wdata[1], reg_wdata[0]};

    // Set terms are OR-ed after the clear so a simultaneous event always wins.
    assign w_icr_set = {txdlow_evt, txqe_evt, w_txdw_set} | (w_ics_wr ? w_wbits : 3'b000);
    assign w_icr_clr = w_icr_rd ? 3'b111 : (w_icr_wr ? w_wbits : 3'b000);

    always_comb begin
        w_rdata = 32'd0;
        case (reg_addr)
            ADDR_ICR:  w_rdata = {16'd0, r_icr[2], 13'd0, r_icr[1], r_icr[0]};
            ADDR_IMS:  w_rdata = {16'd0, r_ims[2], 13'd0, r_ims[1], r_ims[0]};
            ADDR_TIDV: w_rdata = {16'd0, r_tidv};
            ADDR_TADV: w_rdata = {16'd0, r_tadv};
            default:   w_rdata = 32'd0;
        endcase
    end

    // Upper write-data bits have no storage in any register of this block.
    assign w_unused = ^reg_wdata[31:16] ^ ^reg_wdata[14:2];

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (w_any_rst) begin
            r_icr      <= 3'b000;
            r_ims      <= 3'b000;
            r_tidv     <= 16'd0;
            r_tadv     <= 16'd0;
            r_dly      <= 16'd0;
            r_abs      <= 16'd0;
            r_dly_run  <= 1'b0;
            r_abs_run  <= 1'b0;
            r_presc    <= '0;
            reg_rdata  <= 32'd0;
            reg_rvalid <= 1'b0;
            intr       <= 1'b0;
        end else begin
            r_presc    <= w_tick ? '0 : r_presc + PW'(1);
            r_icr      <= (r_icr & ~w_icr_clr) | w_icr_set;
            r_ims      <= (r_ims | (w_ims_wr ? w_wbits : 3'b000)) & ~(w_imc_wr ? w_wbits : 3'b000);
            reg_rvalid <= reg_rd;
            reg_rdata  <= reg_rd ? w_rdata : 32'd0;
            intr       <= |(r_icr & r_ims);

            if (reg_wr && reg_addr == ADDR_TIDV) r_tidv <= reg_wdata[15:0];
            if (reg_wr && reg_addr == ADDR_TADV) r_tadv <= reg_wdata[15:0];

            if (w_reload) begin
                r_dly     <= r_tidv;
                r_dly_run <= 1'b1;
            end else if (w_txdw_set) begin
                r_dly     <= 16'd0;
                r_dly_run <= 1'b0;
            end else if (r_dly_run && w_tick) begin
                r_dly     <= r_dly - 16'd1;
            end

            // A running ABS is never reloaded by later write-backs.
            if (w_txdw_set) begin
                r_abs     <= 16'd0;
                r_abs_run <= 1'b0;
            end else if (w_reload && !r_abs_run && r_tadv != 16'd0) begin
                r_abs     <= r_tadv;
                r_abs_run <= 1'b1;
            end else if (r_abs_run && w_tick) begin
                r_abs     <= r_abs - 16'd1;
            end
        end
    end

endmodule

// File: doc/tx_intr_moderator.md
TX_INTR_MODERATOR -- requirements
Module: tx_intr_moderator

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 128, meaning clock cycles per 1.024 us timer tick (128 at 125 MHz).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port soft_rst, input, 1 bit: single-cycle pulse from CTRL.RST, with the same effect as rst.
REQ-005 The block SHALL have port wb_valid, input, 1 bit: single-cycle pulse, one TX descriptor write-back completed.
REQ-006 The block SHALL have port wb_ide, input, 1 bit: IDE bit of that descriptor, sampled with wb_valid.
REQ-007 The block SHALL have port txqe_evt, input, 1 bit: pulse, transmit queue became empty (TDH==TDT).
REQ-008 The block SHALL have port txdlow_evt, input, 1 bit: pulse, descriptor count fell below TXDCTL.LWTHRESH.
REQ-009 The block SHALL have ports reg_wr and reg_rd, input, 1 bit each: register write or read strobe, mutually exclusive.
REQ-010 The block SHALL have ports reg_addr (input, 16 bits, byte offset in BAR0) and reg_wdata (input, 32 bits).
REQ-011 The block SHALL have ports reg_rdata (output, 32 bits) and reg_rvalid (output, 1 bit): read data and its 1-cycle strobe.
REQ-012 The block SHALL have port intr, output, 1 bit: registered level interrupt request, active-high (INTA_N driver inverts it).

Function
REQ-013 The block SHALL decode registers ICR 0x00C0 (RC/W1C), ICS 0x00C8 (WO), IMS 0x00D0 (RW set), IMC 0x00D8 (WO), TIDV 0x3820 (RW, bits [15:0]) and TADV 0x382C (RW, bits [15:0]).
REQ-014 The block SHALL implement ICR bits 0 TXDW, 1 TXQE and 15 TXD_LOW; all other ICR and IMS bits SHALL read 0 and ignore writes.
REQ-015 The block SHALL assert reg_rvalid exactly 1 cycle after reg_rd, with reg_rdata valid in that cycle; unmapped, ICS and IMC reads SHALL return 0.
REQ-016 A read of ICR SHALL return the current value and then clear all ICR bits in the same cycle as reg_rd.
REQ-017 Writes SHALL have these effects: ICR write clears bits set in wdata; ICS write sets them; IMS write ORs wdata into the mask; IMC write clears mask bits.
REQ-018 When a set event and a clear (ICR read or W1C) hit the same bit in the same cycle, set SHALL win.
REQ-019 txqe_evt SHALL set ICR.TXQE and txdlow_evt SHALL set ICR.TXD_LOW on the next clock edge.
REQ-020 A free-running prescaler SHALL count 0..TICK_DIV-1 and generate a 1-cycle tick at wrap.
REQ-021 The block SHALL keep two 16-bit down-counters, DLY (TIDV) and ABS (TADV), each with a running flag.
REQ-022 On wb_valid with wb_ide=0 or TIDV=0, the block SHALL set ICR.TXDW next cycle and stop both timers.
REQ-023 On wb_valid with wb_ide=1 and TIDV!=0, the block SHALL reload DLY=TIDV and start it; if ABS is idle and TADV!=0, it SHALL load ABS=TADV and start it, and a running ABS SHALL NOT reload.
REQ-024 On a tick, each running counter SHALL decrement; a counter going 1->0 SHALL expire, which sets ICR.TXDW and stops both timers.
REQ-025 Delay accuracy SHALL be (N-1)*TICK_DIV < cycles to TXDW <= N*TICK_DIV+1 for a programmed value N.
REQ-026 A wb_valid reload in the same cycle as a DLY expiry SHALL take priority: no TXDW, and DLY reloads; an ABS expiry in that cycle SHALL still fire.
REQ-027 Writing TIDV or TADV SHALL NOT affect running counters; new values SHALL apply at the next load.
REQ-028 intr SHALL be registered as |(ICR & IMS), so it follows any ICR or IMS change by 1 cycle.

Reset
REQ-029 On rst or soft_rst, the block SHALL clear ICR, IMS, TIDV, TADV, both counters, the running flags and the prescaler, and drive intr=0, reg_rvalid=0 and reg_rdata=0.
REQ-030 A reset during a running delay SHALL cancel it with no later TXDW.

Verification
REQ-031 Immediate path: IMS=0x1, wb_valid with ide=0 -> ICR=0x1 and intr=1 two cycles later; ICR read returns 0x1, then intr=0 after 1 cycle.
REQ-032 Delay path: TICK_DIV=4, TIDV=3, TADV=0, one ide=1 write-back -> TXDW set between 9 and 13 cycles after wb_valid.
REQ-033 Absolute cap: TIDV=4, TADV=6, TICK_DIV=4, ide=1 write-backs every 8 cycles -> TXDW set at ABS expiry, between 21 and 25 cycles after the first write-back.
REQ-034 Masking: ICS=0x8003 with IMS=0 -> intr=0; IMS write 0x8000 -> intr=1; IMC write 0x8000 -> intr=0; ICR read = 0x8003.
REQ-035 Collision: ICR read in the same cycle as txqe_evt -> rdata excludes or includes TXQE per the pre-edge value, and ICR.TXQE=1 afterward.
REQ-036 Mid-delay reset: soft_rst while DLY is running -> no TXDW for 2*TIDV ticks, and all registers read 0.
